// File: rtl/sw_accumulator_pkg.sv
// Shared types and constants for the switch/key accumulator.
package sw_acc_pkg;

  localparam int PRESS_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } deb_state_t;

  // Width of a counter that must reach cycles-1, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sw_accumulator_if.sv
// User-interface bundle between the switch/key pins and the accumulator.
interface sw_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
);
  import sw_acc_pkg::*;

  logic [DATA_W-1:0]      sw_in;
  logic                   acc_key;
  logic                   clear_key;
  logic [ACC_W-1:0]       acc_out;
  logic                   overflow;
  logic [PRESS_CNT_W-1:0] press_count;
  logic                   busy;

  modport master (
    output sw_in, acc_key, clear_key,
    input  acc_out, overflow, press_count, busy
  );

  modport slave (
    input  sw_in, acc_key, clear_key,
    output acc_out, overflow, press_count, busy
  );

endinterface

// File: rtl/sw_accumulator_key_debounce.sv
// Per-key 2-flop synchroniser plus debounce FSM; emits one pulse per accepted press.
module key_debounce
  import sw_acc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic pulse,
  output logic waiting
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [1:0]       sync_reg;
  logic             key_sync;
  deb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  assign key_sync = sync_reg[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg  <= '0;
      state_reg <= IDLE_LOW;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], key_raw};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE_LOW: begin
        if (key_sync) begin
          state_next = WAIT_HIGH;
          cnt_next   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!key_sync)               state_next = IDLE_LOW;
        else if (cnt_reg == CNT_LAST) state_next = HIGH;
        else                          cnt_next   = cnt_reg + CNT_W'(1);
      end
      HIGH: begin
        if (!key_sync) begin
          state_next = WAIT_LOW;
          cnt_next   = '0;
        end
      end
      WAIT_LOW: begin
        if (key_sync)                 state_next = HIGH;
        else if (cnt_reg == CNT_LAST) state_next = IDLE_LOW;
        else                          cnt_next   = cnt_reg + CNT_W'(1);
      end
      default: state_next = IDLE_LOW;
    endcase
  end

  // Pulse is combinational so the datapath updates on the same edge the FSM reaches HIGH.
  always_comb begin
    pulse   = (state_reg == WAIT_HIGH) && key_sync && (cnt_reg == CNT_LAST);
    waiting = (state_reg == WAIT_HIGH) || (state_reg == WAIT_LOW);
  end

endmodule

// File: rtl/sw_accumulator.sv
// Debounced switch accumulator: sums sw_in on accumulate presses, clears on clear presses.
// Optional feature macro ACC_SATURATE_EN: saturate at all-ones instead of wrapping on carry-out.
module sw_accumulator
  import sw_acc_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int ACC_W           = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic              clk,
  input logic              reset,
  sw_accumulator_if.slave  bus
);

  if (DATA_W > ACC_W) begin : g_bad_width
    $error("sw_accumulator: DATA_W must not exceed ACC_W");
  end

  localparam int KEY_ACC = 0;
  localparam int KEY_CLR = 1;

  logic [1:0] key_raw, key_pulse, key_wait;

  assign key_raw[KEY_ACC] = bus.acc_key;
  assign key_raw[KEY_CLR] = bus.clear_key;

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .key_raw(key_raw[gi]),
      .pulse  (key_pulse[gi]),
      .waiting(key_wait[gi])
    );
  end

  logic [DATA_W-1:0]      sw_meta_reg, sw_sync_reg;
  logic [ACC_W-1:0]       acc_reg, acc_next;
  logic                   overflow_reg, overflow_next;
  logic [PRESS_CNT_W-1:0] press_reg, press_next;
  logic [ACC_W:0]         sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      acc_reg      <= '0;
      overflow_reg <= 1'b0;
      press_reg    <= '0;
    end else begin
      sw_meta_reg  <= bus.sw_in;
      sw_sync_reg  <= sw_meta_reg;
      acc_reg      <= acc_next;
      overflow_reg <= overflow_next;
      press_reg    <= press_next;
    end
  end

  // Clear takes priority; a simultaneous accumulate is dropped and not counted.
  always_comb begin
    sum           = {1'b0, acc_reg} + (ACC_W + 1)'(sw_sync_reg);
    acc_next      = acc_reg;
    overflow_next = overflow_reg;
    press_next    = press_reg;
    if (key_pulse[KEY_CLR]) begin
      acc_next      = '0;
      overflow_next = 1'b0;
      press_next    = '0;
    end else if (key_pulse[KEY_ACC]) begin
      press_next = press_reg + PRESS_CNT_W'(1);
      if (sum[ACC_W]) begin
        overflow_next = 1'b1;
`ifdef ACC_SATURATE_EN
        acc_next = '1;
`else
        acc_next = sum[ACC_W-1:0];
`endif
      end else begin
        acc_next = sum[ACC_W-1:0];
      end
    end
  end

  assign bus.acc_out     = acc_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.press_count = press_reg;
  assign bus.busy        = |key_wait;

endmodule

// File: tb/tb_sw_accumulator.sv
// Scoreboard bench for sw_accumulator: run-length key model feeds an expected-change queue.
module tb_sw_accumulator;
  import sw_acc_pkg::*;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 8;
  localparam int D      = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sw_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  sw_accumulator #(
    .DATA_W(DATA_W),
    .ACC_W(ACC_W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    int unsigned cyc;
    int unsigned acc;
    bit          ovf;
    int unsigned cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  bit          mon_en   = 1'b0;

  // Reference model state.
  int unsigned m_acc = 0, m_cnt = 0;
  bit          m_ovf = 0, m_busy = 0;
  bit          key_mode[2];
  int          key_run[2];
  bit          ka_q[$], kc_q[$];
  int unsigned sw_q[$];
  int unsigned o_acc, o_cnt, sw_s, sum;
  bit          o_ovf, pa, pc;
  exp_t        push_e, mon_e;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, got, want);
    end
  endtask

  // A key is accepted after D+1 consecutive samples differing from its settled level.
  function automatic bit deb_step(input int k, input bit s);
    bit fire;
    fire = 1'b0;
    if (s != key_mode[k]) begin
      key_run[k]++;
      if (key_run[k] == D + 1) begin
        fire        = !key_mode[k];
        key_mode[k] = s;
        key_run[k]  = 0;
      end
    end else begin
      key_run[k] = 0;
    end
    return fire;
  endfunction

  always @(posedge clk) begin
    cyc++;
    o_acc = m_acc; o_ovf = m_ovf; o_cnt = m_cnt;
    if (reset) begin
      m_acc = 0; m_ovf = 0; m_cnt = 0;
      key_mode[0] = 0; key_mode[1] = 0;
      key_run[0]  = 0; key_run[1]  = 0;
      ka_q = {1'b0, 1'b0};
      kc_q = {1'b0, 1'b0};
      sw_q = {32'd0, 32'd0};
    end else begin
      // Decisions at this edge use raw inputs from two edges earlier.
      pa   = deb_step(0, ka_q.pop_front());
      pc   = deb_step(1, kc_q.pop_front());
      sw_s = sw_q.pop_front();
      ka_q.push_back(bus.acc_key);
      kc_q.push_back(bus.clear_key);
      sw_q.push_back(int'(bus.sw_in));
      if (pc) begin
        m_acc = 0; m_ovf = 0; m_cnt = 0;
      end else if (pa) begin
        sum   = m_acc + sw_s;
        m_cnt = (m_cnt + 1) % 256;
        if (sum >= (1 << ACC_W)) begin
          m_ovf = 1;
`ifdef ACC_SATURATE_EN
          m_acc = (1 << ACC_W) - 1;
`else
          m_acc = sum % (1 << ACC_W);
`endif
        end else begin
          m_acc = sum;
        end
      end
    end
    m_busy = (key_run[0] != 0) || (key_run[1] != 0);
    if (m_acc != o_acc || m_ovf != o_ovf || m_cnt != o_cnt) begin
      push_e.cyc = cyc; push_e.acc = m_acc; push_e.ovf = m_ovf; push_e.cnt = m_cnt;
      exp_q.push_back(push_e);
    end
  end

  logic [ACC_W-1:0]       p_acc;
  logic                   p_ovf;
  logic [PRESS_CNT_W-1:0] p_cnt;

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", int'(bus.busy), int'(m_busy));
      if (bus.acc_out !== p_acc || bus.overflow !== p_ovf || bus.press_count !== p_cnt) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_update cyc=%0d got acc=0x%0h ovf=%0b cnt=%0d want no change",
                   cyc, bus.acc_out, bus.overflow, bus.press_count);
        end else begin
          mon_e = exp_q.pop_front();
          checks++;
          if (mon_e.cyc != cyc || bus.acc_out !== ACC_W'(mon_e.acc) ||
              bus.overflow !== mon_e.ovf || bus.press_count !== PRESS_CNT_W'(mon_e.cnt)) begin
            failures++;
            $display("FAIL update got cyc=%0d acc=0x%0h ovf=%0b cnt=%0d want cyc=%0d acc=0x%0h ovf=%0b cnt=%0d",
                     cyc, bus.acc_out, bus.overflow, bus.press_count,
                     mon_e.cyc, mon_e.acc, mon_e.ovf, mon_e.cnt);
          end else begin
            $display("update cyc=%0d acc=0x%0h ovf=%0b cnt=%0d", cyc, bus.acc_out, bus.overflow,
                     bus.press_count);
          end
        end
      end
    end
    p_acc = bus.acc_out;
    p_ovf = bus.overflow;
    p_cnt = bus.press_count;
  end

  task automatic hold_keys(input bit a, input bit c, input int n, input bit rand_sw);
    bus.acc_key   = a;
    bus.clear_key = c;
    repeat (n) begin
      if (rand_sw) bus.sw_in = DATA_W'($urandom_range(0, 255));
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  int busy_seen;
  int kind;

  initial begin
    reset = 1'b1;
    bus.sw_in = '0; bus.acc_key = 1'b0; bus.clear_key = 1'b0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle after reset.
    hold_keys(0, 0, 20, 0);
    check("reset_acc", int'(bus.acc_out), 0);
    check("reset_ovf", int'(bus.overflow), 0);
    check("reset_cnt", int'(bus.press_count), 0);
    check("reset_busy", int'(bus.busy), 0);

    // Long hold gives exactly one accumulate.
    bus.sw_in = 8'h05;
    hold_keys(1, 0, 30, 0);
    hold_keys(0, 0, 10, 0);
    check("hold_acc", int'(bus.acc_out), 'h05);
    check("hold_cnt", int'(bus.press_count), 1);

    // Bounce shorter than the debounce window is ignored.
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      hold_keys(1, 0, 2, 0);
      busy_seen += int'(bus.busy);
      hold_keys(0, 0, 2, 0);
      busy_seen += int'(bus.busy);
    end
    hold_keys(0, 0, 10, 0);
    check("bounce_busy_seen", int'(busy_seen > 0), 1);
    check("bounce_acc", int'(bus.acc_out), 'h05);

    // Clear, then overflow on the second 0xF0 press.
    hold_keys(0, 1, 8, 0);
    hold_keys(0, 0, 8, 0);
    bus.sw_in = 8'hF0;
    hold_keys(1, 0, 8, 0);
    hold_keys(0, 0, 8, 0);
    check("ovf_first_acc", int'(bus.acc_out), 'hF0);
    hold_keys(1, 0, 8, 0);
    hold_keys(0, 0, 8, 0);
`ifdef ACC_SATURATE_EN
    check("ovf_second_acc", int'(bus.acc_out), 'hFF);
`else
    check("ovf_second_acc", int'(bus.acc_out), 'hE0);
`endif
    check("ovf_flag", int'(bus.overflow), 1);
    check("ovf_cnt", int'(bus.press_count), 2);

    // Both keys together: clear wins.
    hold_keys(1, 1, 10, 0);
    hold_keys(0, 0, 10, 0);
    check("both_acc", int'(bus.acc_out), 0);
    check("both_ovf", int'(bus.overflow), 0);
    check("both_cnt", int'(bus.press_count), 0);

    // Reset mid-debounce with the key still held.
    bus.sw_in = 8'h33;
    hold_keys(1, 0, 4, 0);
    do_reset(1);
    hold_keys(1, 0, 15, 0);
    hold_keys(0, 0, 10, 0);
    check("rst_mid_acc", int'(bus.acc_out), 'h33);

    // Randomised key activity with sw_in changing every cycle.
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0:       do_reset($urandom_range(1, 3));
        1, 2:    hold_keys(1, 1, $urandom_range(1, 12), 1);
        3:       hold_keys(0, 1, $urandom_range(1, 12), 1);
        4:       hold_keys($urandom_range(0, 1) != 0, 0, $urandom_range(1, 3), 1);
        default: hold_keys(1, 0, $urandom_range(1, 12), 1);
      endcase
      hold_keys(0, 0, $urandom_range(1, 12), 1);
    end
    hold_keys(0, 0, 20, 0);

    check("queue_drained", exp_q.size(), 0);
    check("final_acc", int'(bus.acc_out), int'(m_acc));
    check("final_cnt", int'(bus.press_count), int'(m_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_accumulator.md
# sw_accumulator

Parametrised hardware accumulator for the switch/key user interface of the Nios II lab system. It sums the switch value into a register on each debounced press of the accumulate key and clears on the clear key. It handles arbitrary switch and accumulator widths, tracks overflow, and counts presses, in fabric beside the SoC. Its output drives the LED bank directly, or is exported to the SoC as a PIO input.

## Interface
- DATA_W, 8: switch input width
- ACC_W, 16: accumulator width; DATA_W <= ACC_W (elaboration error otherwise)
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples required to accept a key edge; >= 1
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  synchronous, active-high
- sw_in  in  DATA_W  raw switch value (asynchronous)
- acc_key  in  1  raw accumulate key, active-high (top level passes ~KEY[3])
- clear_key  in  1  raw clear key, active-high (top level passes ~KEY[2])
- acc_out  out  ACC_W  accumulator value
- overflow  out  1  sticky overflow/saturation flag
- press_count  out  8  accepted accumulate presses, modulo 256
- busy  out  1  high while either key debouncer is in a WAIT state

## Operation
- sw_in, acc_key and clear_key each pass through a 2-flop synchroniser.
- Each key has its own debounce FSM: IDLE_LOW, WAIT_HIGH, HIGH, WAIT_LOW.
  - IDLE_LOW: sync=1 -> WAIT_HIGH, cnt<=0.
  - WAIT_HIGH: sync=0 -> IDLE_LOW. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> HIGH with a one-cycle press pulse; else cnt++.
  - HIGH: sync=0 -> WAIT_LOW, cnt<=0.
  - WAIT_LOW: mirror of WAIT_HIGH, returning to IDLE_LOW. No pulse on release.
- Accumulate pulse: sum = acc_out + zero-extended synchronised sw_in, computed ACC_W+1 bits wide.
  - Carry-out=0: acc_out<=sum.
  - Carry-out=1: see Configuration. overflow<=1.
  - press_count increments by 1 and wraps 255->0.
- Clear pulse: acc_out<=0, overflow<=0, press_count<=0.
- Both pulses in the same cycle: clear wins; the accumulate is discarded and not counted.
- Holding a key produces exactly one pulse. Bounce shorter than DEBOUNCE_CYCLES produces none.

## Timing
- Reset (synchronous, priority over everything): acc_out=0, overflow=0, press_count=0, busy=0. Debouncers go to IDLE_LOW, cnt=0, synchronisers cleared.
- Key first sampled high at edge N and held: press pulse is combinational in the cycle ending at edge N+DEBOUNCE_CYCLES+2, and the registers update at that edge.
- The summed sw_in is the synchronised value at that edge, i.e. raw sw_in from 2 cycles earlier.
- Reset asserted mid-debounce: the press is lost. After reset, a key still held is treated as a new press and needs the full debounce.
- Minimum press-to-press spacing: 2*DEBOUNCE_CYCLES+4 cycles.

## Configuration
- ACC_SATURATE_EN defined: on carry-out, acc_out<=all-ones ({ACC_W{1'b1}}) and stays there on further accumulates until cleared. overflow<=1.
- Not defined: acc_out<=sum[ACC_W-1:0] (wrap-around), overflow<=1.

## Structure
- Package sw_acc_pkg: debounce state enum (IDLE_LOW, WAIT_HIGH, HIGH, WAIT_LOW) and the constant PRESS_CNT_W=8.
- Sub-module key_debounce: synchroniser, FSM and counter, with ports clk, reset, key_raw, pulse, waiting. Instantiated twice (accumulate, clear).
- The top-level sw_accumulator holds the sw_in synchroniser, the datapath and the counters.

## Test plan
Benches use DATA_W=8, ACC_W=8, DEBOUNCE_CYCLES=4.
- Reset then idle 20 cycles -> acc_out=0x00, overflow=0, press_count=0, busy=0.
- sw_in=0x05, acc_key high from edge 10 and held 30 cycles -> acc_out=0x05 at edge 16, press_count=1. No further change while held.
- acc_key toggled high 2 cycles / low 2 cycles for 40 cycles -> no pulse, acc_out unchanged, busy toggles.
- sw_in=0xF0, two clean presses -> first gives acc_out=0xF0. Second gives 0xE0 with overflow=1 when not defined, 0xFF with overflow=1 under ACC_SATURATE_EN.
- acc_key and clear_key raised on the same edge and held -> acc_out=0, overflow=0, press_count=0 at edge N+6.
- Reset asserted 2 cycles into WAIT_HIGH with key held -> no accumulate. After reset deasserts, the first update occurs 6 edges after the first post-reset high sample.
